// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between a host (master) and spi_reg_peripheral (slave).
// The host drives sclk/ncs/copi; the peripheral drives cipo and its enable.
interface spi_reg_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target: 16-bit frames {rw, addr[6:0], data[7:0]} write the five
// 8-bit control registers feeding the PWM/output stage. Pins are oversampled
// on clk; a register write commits atomically on the ncs rising edge.
// Optional feature macro: SPI_READBACK_EN (register readback on cipo).
module spi_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, ERR} state_t;

  // After reset, ncs falls are masked until the synchronizer and edge flop
  // have flushed, so a chip select held low through reset cannot start a frame.
  localparam int SETTLE   = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic                   sclk_d, ncs_d;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic                   settled;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_sr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign settled   = (settle_cnt == SETTLE_W'(SETTLE));
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = settled & ~ncs_s & ncs_d;

  // Pin synchronizers plus one edge-detect flop; ncs idles high, sclk low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= '0;
      ncs_sync   <= '1;
      copi_sync  <= '0;
      sclk_d     <= 1'b0;
      ncs_d      <= 1'b1;
      settle_cnt <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      if (!settled) settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

`ifdef SPI_READBACK_EN
  logic       cipo_q;
  logic       rd_oe;
  logic [7:0] rd_data;
  logic [6:0] rd_addr;
  logic [7:0] rd_mux;

  // Address is complete once the 8th bit arrives: 7 bits already shifted + copi.
  assign rd_addr = {shift_sr[5:0], copi_s};

  // Register readback select; unmapped or out-of-range addresses read as zero.
  always_comb begin
    rd_mux = 8'h00;
    if (rd_addr <= MAX_ADDR) begin
      case (rd_addr)
        7'h00:   rd_mux = en_reg_out_7_0;
        7'h01:   rd_mux = en_reg_out_15_8;
        7'h02:   rd_mux = en_reg_pwm_7_0;
        7'h03:   rd_mux = en_reg_pwm_15_8;
        7'h04:   rd_mux = pwm_duty_cycle;
        default: rd_mux = 8'h00;
      endcase
    end
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = rd_oe;
`else
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

  // Frame FSM, shift register and commit of the control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift_sr        <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      frame_err       <= 1'b0;
`ifdef SPI_READBACK_EN
      cipo_q          <= 1'b0;
      rd_oe           <= 1'b0;
      rd_data         <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (ncs_rise) begin
        state <= IDLE;
        if (state == FULL) begin
          if (shift_sr[15] && (shift_sr[14:8] <= MAX_ADDR)) begin
            case (shift_sr[14:8])
              7'h00:   en_reg_out_7_0  <= shift_sr[7:0];
              7'h01:   en_reg_out_15_8 <= shift_sr[7:0];
              7'h02:   en_reg_pwm_7_0  <= shift_sr[7:0];
              7'h03:   en_reg_pwm_15_8 <= shift_sr[7:0];
              7'h04:   pwm_duty_cycle  <= shift_sr[7:0];
              default: ;
            endcase
          end
        end else if (state == SHIFT || state == ERR) begin
          frame_err <= 1'b1;
        end
`ifdef SPI_READBACK_EN
        rd_oe  <= 1'b0;
        cipo_q <= 1'b0;
`endif
      end else if (ncs_fall) begin
        state    <= SHIFT;
        bit_cnt  <= '0;
        shift_sr <= '0;
`ifdef SPI_READBACK_EN
        rd_oe    <= 1'b0;
        cipo_q   <= 1'b0;
`endif
      end else if (sclk_rise) begin
        case (state)
          SHIFT: begin
            shift_sr <= {shift_sr[14:0], copi_s};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) state <= FULL;
`ifdef SPI_READBACK_EN
            if (bit_cnt == 5'd0) rd_oe <= ~copi_s;
            if (bit_cnt == 5'd7) rd_data <= rd_mux;
`endif
          end
          FULL: begin
            state <= ERR;
`ifdef SPI_READBACK_EN
            rd_oe <= 1'b0;
`endif
          end
          default: ;
        endcase
      end else if (sclk_fall) begin
`ifdef SPI_READBACK_EN
        // Falls after bits 8..15 carry the latched byte out, MSB first.
        if (rd_oe && (bit_cnt >= 5'd8) && (bit_cnt < 5'd16)) begin
          cipo_q  <= rd_data[7];
          rd_data <= {rd_data[6:0], 1'b0};
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: a table of frames with expected
// register images, plus hand-written reset-mid-frame and readback sequences.
module tb_spi_reg_peripheral;
  localparam int H = 6; // clk periods per sclk phase / ncs guard

  logic clk = 1'b0;
  logic rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic frame_err;

  spi_reg_peripheral_if spi_bus ();

  spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi_bus),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  wire [39:0] dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                          en_reg_out_15_8, en_reg_out_7_0};

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  logic [31:0] cap_cipo = '0;
  logic [31:0] cap_oe = '0;
  logic [39:0] cur_regs = '0;

  typedef struct {
    string       name;
    logic [31:0] bits;
    int          nbits;
    logic [39:0] exp_regs;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock out n bits MSB first; cipo/cipo_oe are captured just before each rise.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_bus.copi = bits[i];
      wait_clk(H);
      cap_cipo = {cap_cipo[30:0], spi_bus.cipo};
      cap_oe   = {cap_oe[30:0], spi_bus.cipo_oe};
      spi_bus.sclk = 1'b1;
      wait_clk(H);
      spi_bus.sclk = 1'b0;
    end
    wait_clk(H);
  endtask

  task automatic start_frame();
    spi_bus.ncs = 1'b0;
    wait_clk(H);
  endtask

  // Raise ncs and check outputs hold for 2 clocks, then update on the 3rd.
  task automatic finish_frame(input string name, input logic [39:0] exp_regs, input logic exp_err);
    spi_bus.ncs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({name, " hold"}, dut_regs, cur_regs);
    check({name, " err_early"}, {39'd0, frame_err}, 40'd0);
    @(posedge clk);
    #1;
    check({name, " regs"}, dut_regs, exp_regs);
    check({name, " err"}, {39'd0, frame_err}, {39'd0, exp_err});
    cur_regs = exp_regs;
    wait_clk(H);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wr a0 A5",     32'h80A5,        16, 40'h00_00_00_00_A5, 1'b0};
    vecs[1] = '{"wr a4 7F",     32'h847F,        16, 40'h7F_00_00_00_A5, 1'b0};
    vecs[2] = '{"wr a3 0F",     32'h830F,        16, 40'h7F_0F_00_00_A5, 1'b0};
    vecs[3] = '{"wr a5 bad",    32'h85FF,        16, 40'h7F_0F_00_00_A5, 1'b0};
    vecs[4] = '{"short 15b",    32'h8011 >> 1,   15, 40'h7F_0F_00_00_A5, 1'b1};
    vecs[5] = '{"long 17b",     32'h10045,       17, 40'h7F_0F_00_00_A5, 1'b1};
    vecs[6] = '{"read a1",      32'h013C,        16, 40'h7F_0F_00_00_A5, 1'b0};
    vecs[7] = '{"wr a1 55",     32'h8155,        16, 40'h7F_0F_00_55_A5, 1'b0};
    vecs[8] = '{"wr a2 99",     32'h8299,        16, 40'h7F_0F_99_55_A5, 1'b0};

    rst = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.ncs  = 1'b1;
    spi_bus.copi = 1'b0;
    wait_clk(3);
    check("reset regs", dut_regs, 40'd0);
    check("reset cipo", {38'd0, spi_bus.cipo, spi_bus.cipo_oe}, 40'd0);
    check("reset err", {39'd0, frame_err}, 40'd0);
    rst = 1'b0;
    wait_clk(10);

    for (int v = 0; v < 9; v++) begin
      start_frame();
      send_bits(vecs[v].bits, vecs[v].nbits);
      finish_frame(vecs[v].name, vecs[v].exp_regs, vecs[v].exp_err);
    end
    check("err pulses table", 40'(err_pulses), 40'd2);

    // Reset after 10 bits of a write to addr 2, ncs held low throughout.
    start_frame();
    send_bits(32'h82AB >> 6, 10);
    rst = 1'b1;
    wait_clk(2);
    check("mid rst regs", dut_regs, 40'd0);
    rst = 1'b0;
    send_bits(32'h82AB & 32'h3F, 6);
    spi_bus.ncs = 1'b1;
    wait_clk(10);
    cur_regs = '0;
    check("after rst regs", dut_regs, 40'd0);
    check("err pulses rst", 40'(err_pulses), 40'd2);
    start_frame();
    send_bits(32'h823C, 16);
    finish_frame("wr a2 3C", 40'h00_00_3C_00_00, 1'b0);

    // Readback of register 1.
    start_frame();
    send_bits(32'h81C3, 16);
    finish_frame("wr a1 C3", 40'h00_00_3C_C3_00, 1'b0);
    start_frame();
    send_bits(32'h0100, 16);
    finish_frame("rd a1", 40'h00_00_3C_C3_00, 1'b0);
`ifdef SPI_READBACK_EN
    check("rd cipo bits", {32'd0, cap_cipo[7:0]}, 40'hC3);
    check("rd cipo_oe", {32'd0, cap_oe[7:0]}, 40'hFF);
`else
    check("rd cipo bits", {32'd0, cap_cipo[7:0]}, 40'h00);
    check("rd cipo_oe", {32'd0, cap_oe[7:0]}, 40'h00);
`endif
    check("idle cipo_oe", {39'd0, spi_bus.cipo_oe}, 40'd0);
    check("err pulses end", 40'(err_pulses), 40'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
